// File: rtl/pcm_capture_ctrl_if.sv
// Sample stream handshake between pcm_capture_ctrl (master) and the bus side (slave).
interface pcm_capture_ctrl_if;
  logic signed [15:0] smp_data;
  logic               smp_valid;
  logic               smp_ready;

  modport master (output smp_data, output smp_valid, input smp_ready);
  modport slave  (input smp_data, input smp_valid, output smp_ready);
endinterface

// File: rtl/pcm_capture_ctrl.sv
// Microphone PCM chain sequencer: chain reset, config latch, warm-up discard, 4-entry sample FIFO.
// Optional peak-magnitude tracker enabled by defining PCM_CAPTURE_PEAK_EN.
module pcm_capture_ctrl #(
  parameter int WARM_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [7:0]          cfg_prescaler,
  input  logic signed [15:0]  cfg_b0,
  input  logic signed [15:0]  cfg_b1,
  input  logic [WARM_W-1:0]   cfg_warmup,
  input  logic                ce_pcm,
  input  logic signed [15:0]  fir_out,
  output logic                chain_rst,
  output logic [7:0]          prescaler,
  output logic signed [15:0]  b0,
  output logic signed [15:0]  b1,
  pcm_capture_ctrl_if.master  smp,
  output logic                busy,
  output logic                overflow
`ifdef PCM_CAPTURE_PEAK_EN
  ,
  output logic [15:0]         peak
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  state_t              state_r;
  logic [1:0]          rst_cnt_r;
  logic [WARM_W-1:0]   warm_cnt_r;
  logic [WARM_W-1:0]   warm_cfg_r;
  logic [WARM_W-1:0]   warm_inc_s;
  logic                chain_rst_r;
  logic [7:0]          prescaler_r;
  logic signed [15:0]  b0_r;
  logic signed [15:0]  b1_r;
  logic                busy_r;
  logic                overflow_r;
  logic                strobe_r;

  logic signed [15:0]  mem_r [4];
  logic [1:0]          wr_ptr_r;
  logic [1:0]          rd_ptr_r;
  logic [2:0]          count_r;
  logic                smp_valid_r;
  logic signed [15:0]  smp_data_r;

  logic                push_s;
  logic                pop_s;
  logic                wr_en_s;
  logic                drop_s;
  logic                flush_s;
  logic [2:0]          count_nxt_s;
  logic [1:0]          rd_ptr_nxt_s;
  logic signed [15:0]  head_nxt_s;

  assign chain_rst     = chain_rst_r;
  assign prescaler     = prescaler_r;
  assign b0            = b0_r;
  assign b1            = b1_r;
  assign busy          = busy_r;
  assign overflow      = overflow_r;
  assign smp.smp_valid = smp_valid_r;
  assign smp.smp_data  = smp_data_r;

  // FIFO control and next-head selection; a write into the slot that becomes head is forwarded into the head register
  always_comb begin
    push_s       = strobe_r && (state_r == ST_RUN);
    pop_s        = smp_valid_r && smp.smp_ready;
    wr_en_s      = push_s && ((count_r != 3'd4) || pop_s);
    drop_s       = push_s && (count_r == 3'd4) && !pop_s;
    flush_s      = (state_r == ST_IDLE) ||
                   ((state_r == ST_WARMUP) && stop) ||
                   ((state_r == ST_DRAIN) && (count_r == 3'd0));
    count_nxt_s  = count_r + {2'b00, wr_en_s} - {2'b00, pop_s};
    rd_ptr_nxt_s = rd_ptr_r + {1'b0, pop_s};
    warm_inc_s   = warm_cnt_r + WARM_W'(1);
    if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = fir_out;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Session FSM with registered chain reset, config latch, busy, strobe pipeline and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rst_cnt_r   <= 2'd0;
      warm_cnt_r  <= {WARM_W{1'b0}};
      warm_cfg_r  <= {WARM_W{1'b0}};
      chain_rst_r <= 1'b1;
      prescaler_r <= 8'd0;
      b0_r        <= 16'sd0;
      b1_r        <= 16'sd0;
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
      strobe_r    <= 1'b0;
    end else begin
      busy_r     <= (state_r != ST_IDLE);
      strobe_r   <= chain_rst_r ? 1'b0 : ce_pcm;
      overflow_r <= ((state_r == ST_IDLE) && start) ? 1'b0 : (overflow_r | drop_s);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            prescaler_r <= cfg_prescaler;
            b0_r        <= cfg_b0;
            b1_r        <= cfg_b1;
            warm_cfg_r  <= cfg_warmup;
            rst_cnt_r   <= 2'd0;
            chain_rst_r <= 1'b1;
            state_r     <= ST_RESET;
          end
        end
        ST_RESET: begin
          if (rst_cnt_r == 2'd3) begin
            chain_rst_r <= 1'b0;
            warm_cnt_r  <= {WARM_W{1'b0}};
            state_r     <= (warm_cfg_r == {WARM_W{1'b0}}) ? ST_RUN : ST_WARMUP;
          end else begin
            rst_cnt_r <= rst_cnt_r + 2'd1;
          end
        end
        ST_WARMUP: begin
          if (stop) begin
            chain_rst_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else if (strobe_r) begin
            warm_cnt_r <= warm_inc_s;
            if (warm_inc_s == warm_cfg_r) begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (count_r == 3'd0) begin
            chain_rst_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          chain_rst_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Sample FIFO storage, pointers and head registers; data holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_r[i] <= 16'sd0;
      end
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      smp_valid_r <= 1'b0;
      smp_data_r  <= 16'sd0;
    end else if (flush_s) begin
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      smp_valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= fir_out;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      smp_valid_r <= (count_nxt_s != 3'd0);
      if (count_nxt_s != 3'd0) begin
        smp_data_r <= head_nxt_s;
      end
    end
  end

`ifdef PCM_CAPTURE_PEAK_EN
  logic [15:0] peak_r;

  function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
    if (x == 16'sh8000) begin
      return 16'h7FFF;
    end else if (x < 16'sd0) begin
      return 16'(-x);
    end else begin
      return 16'(x);
    end
  endfunction

  assign peak = peak_r;

  // Peak |sample| over every pushed strobe, including samples dropped on overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      peak_r <= 16'd0;
    end else if (push_s && (abs_sat(fir_out) > peak_r)) begin
      peak_r <= abs_sat(fir_out);
    end
  end
`endif

endmodule

// File: tb/tb_pcm_capture_ctrl.sv
// Scoreboard bench for pcm_capture_ctrl: expected samples queued at stimulus time, checked on pop.
module tb_pcm_capture_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic stop;
  logic [7:0] cfg_prescaler;
  logic signed [15:0] cfg_b0;
  logic signed [15:0] cfg_b1;
  logic [7:0] cfg_warmup;
  logic ce_pcm;
  logic signed [15:0] fir_out;
  logic chain_rst;
  logic [7:0] prescaler;
  logic signed [15:0] b0;
  logic signed [15:0] b1;
  logic busy;
  logic overflow;
`ifdef PCM_CAPTURE_PEAK_EN
  logic [15:0] peak;
`endif

  localparam logic signed [15:0] B0_A = 16'sh0FFF;
  localparam logic signed [15:0] B1_A = 16'sh7FFF;

  pcm_capture_ctrl_if smp_if ();

  pcm_capture_ctrl #(.WARM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_prescaler(cfg_prescaler), .cfg_b0(cfg_b0), .cfg_b1(cfg_b1),
    .cfg_warmup(cfg_warmup), .ce_pcm(ce_pcm), .fir_out(fir_out),
    .chain_rst(chain_rst), .prescaler(prescaler), .b0(b0), .b1(b1),
    .smp(smp_if), .busy(busy), .overflow(overflow)
`ifdef PCM_CAPTURE_PEAK_EN
    , .peak(peak)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic signed [15:0] exp_q[$];
  logic signed [15:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ce_pcm for one clk; the FIR model updates fir_out one clk later, when the strobe samples it
  task automatic pulse(input logic signed [15:0] val, input bit expect_push);
    ce_pcm = 1'b1;
    tick();
    ce_pcm  = 1'b0;
    fir_out = val;
    if (expect_push) exp_q.push_back(val);
    tick();
  endtask

  task automatic do_start(input logic [7:0] p, input logic signed [15:0] c0,
                          input logic signed [15:0] c1, input logic [7:0] w);
    cfg_prescaler = p;
    cfg_b0 = c0;
    cfg_b1 = c1;
    cfg_warmup = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_prescaler", 32'(prescaler), 32'(p));
    check("cfg_b0", 32'(b0), 32'(c0));
    check("cfg_b1", 32'(b1), 32'(c1));
    check("busy_lag", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("chain_rst_hold", 32'(chain_rst), 32'd1);
      if (i == 1) check("busy_rise", 32'(busy), 32'd1);
      tick();
    end
    check("chain_rst_release", 32'(chain_rst), 32'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (!smp_if.smp_valid) break;
      tick();
    end
    check("drain_done", 32'(smp_if.smp_valid), 32'd0);
  endtask

  // Scoreboard: every handshake pops one expected sample in order
  always @(negedge clk) begin
    if (!rst && smp_if.smp_valid && smp_if.smp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_data", 32'(smp_if.smp_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic signed [15:0] s;
    rst = 1'b1; start = 1'b0; stop = 1'b0; ce_pcm = 1'b0; fir_out = 16'sd0;
    cfg_prescaler = 8'd0; cfg_b0 = 16'sd0; cfg_b1 = 16'sd0; cfg_warmup = 8'd0;
    smp_if.smp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_chain_rst", 32'(chain_rst), 32'd1);
    check("rst_prescaler", 32'(prescaler), 32'd0);
    check("rst_b0", 32'(b0), 32'd0);
    check("rst_b1", 32'(b1), 32'd0);
    check("rst_valid", 32'(smp_if.smp_valid), 32'd0);
    check("rst_data", 32'(smp_if.smp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef PCM_CAPTURE_PEAK_EN
    check("rst_peak", 32'(peak), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Session A: warm-up 3, latency, overflow
    do_start(8'd49, B0_A, B1_A, 8'd3);
    for (int i = 0; i < 3; i++) pulse(16'sh1111, 1'b0);
    ce_pcm = 1'b1;
    tick();
    check("lat_cycle1_valid", 32'(smp_if.smp_valid), 32'd0);
    ce_pcm = 1'b0;
    fir_out = 16'sh1234;
    exp_q.push_back(16'sh1234);
    tick();
    check("lat_valid", 32'(smp_if.smp_valid), 32'd1);
    check("lat_data", 32'(smp_if.smp_data), 32'h1234);
    tick();
    check("stall_hold", 32'(smp_if.smp_data), 32'h1234);
    smp_if.smp_ready = 1'b1;
    wait_drain();

    smp_if.smp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s = 16'sh0200 + 16'(i);
      pulse(s, i < 4);
      if (i == 3) check("ovf_after_4", 32'(overflow), 32'd0);
      if (i == 4) check("ovf_after_5", 32'(overflow), 32'd1);
    end
    smp_if.smp_ready = 1'b1;
    wait_drain();
    check("q_empty_a", 32'(exp_q.size()), 32'd0);

    cfg_prescaler = 8'd7; cfg_b0 = 16'sh0001; cfg_b1 = 16'sh0002; cfg_warmup = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("run_start_presc", 32'(prescaler), 32'd49);
    check("run_start_b0", 32'(b0), 32'(B0_A));
    check("run_start_b1", 32'(b1), 32'(B1_A));
    check("run_start_chain", 32'(chain_rst), 32'd0);
    pulse(16'sh0ABC, 1'b1);
    wait_drain();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_chain_rst", 32'(chain_rst), 32'd1);
    check("idle_presc_hold", 32'(prescaler), 32'd49);

    // Session B: warm-up 0, full push+pop, stop with strobe
    do_start(8'd12, 16'sh0100, 16'shFF00, 8'd0);
    check("ovf_cleared", 32'(overflow), 32'd0);
    smp_if.smp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 16'sh0300 + 16'(i);
      pulse(s, 1'b1);
    end
    ce_pcm = 1'b1;
    tick();
    ce_pcm = 1'b0;
    fir_out = 16'sh0304;
    exp_q.push_back(16'sh0304);
    smp_if.smp_ready = 1'b1;
    tick();
    smp_if.smp_ready = 1'b0;
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    pulse(16'sh0305, 1'b0);
    check("full_still_4", 32'(overflow), 32'd1);
    smp_if.smp_ready = 1'b1;
    wait_drain();
    check("q_empty_b", 32'(exp_q.size()), 32'd0);

    smp_if.smp_ready = 1'b0;
    pulse(16'sh0401, 1'b1);
    pulse(16'sh0402, 1'b1);
    ce_pcm = 1'b1;
    tick();
    ce_pcm = 1'b0;
    fir_out = 16'sh0403;
    exp_q.push_back(16'sh0403);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    smp_if.smp_ready = 1'b1;
    wait_drain();
    check("drain_chain_low", 32'(chain_rst), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    tick();
    check("drain_idle_chain", 32'(chain_rst), 32'd1);
    check("drain_idle_busy", 32'(busy), 32'd1);
    tick();
    check("drain_busy_fall", 32'(busy), 32'd0);
    check("q_empty_stop", 32'(exp_q.size()), 32'd0);

    // Session C: stop during warm-up
    do_start(8'd3, 16'sh0011, 16'sh0022, 8'd5);
    pulse(16'sh0555, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("warm_stop_chain", 32'(chain_rst), 32'd1);
    check("warm_stop_valid", 32'(smp_if.smp_valid), 32'd0);
    tick();
    check("warm_stop_busy", 32'(busy), 32'd0);

    // Session D: peak tracking, then asynchronous reset mid-RUN
    do_start(8'd20, 16'sh0033, 16'sh0044, 8'd0);
`ifdef PCM_CAPTURE_PEAK_EN
    check("peak_cleared", 32'(peak), 32'd0);
`endif
    smp_if.smp_ready = 1'b1;
    pulse(16'sd100, 1'b1);
`ifdef PCM_CAPTURE_PEAK_EN
    check("peak_100", 32'(peak), 32'd100);
`endif
    pulse(16'sh8000, 1'b1);
    pulse(16'sd5, 1'b1);
`ifdef PCM_CAPTURE_PEAK_EN
    check("peak_sat", 32'(peak), 32'h7FFF);
`endif
    wait_drain();
    smp_if.smp_ready = 1'b0;
    pulse(16'sh0777, 1'b1);
    check("pre_rst_valid", 32'(smp_if.smp_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(smp_if.smp_valid), 32'd0);
    check("arst_chain_rst", 32'(chain_rst), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_presc", 32'(prescaler), 32'd0);
`ifdef PCM_CAPTURE_PEAK_EN
    check("arst_peak", 32'(peak), 32'd0);
`endif
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    check("q_final", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
